// File: rtl/face_detect_mul_pipe.sv
// Pipelined multiplier with valid/ready handshake, global clock enable and an
// optional multiply-accumulate output stage for dot-product reductions.
// Stage 0 holds the operands, the multiply feeds stage 1, stages 2..STAGES-2
// are pure delay and stage STAGES-1 is the output register (or accumulator).
module face_detect_mul_pipe #(
    parameter int unsigned A_W      = 16,
    parameter int unsigned B_W      = 6,
    parameter int unsigned P_W      = 21,
    parameter int unsigned STAGES   = 4,
    parameter bit          A_SIGNED = 1'b0,
    parameter bit          B_SIGNED = 1'b0,
    parameter bit          ACC_EN   = 1'b0
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           ce,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [A_W-1:0] din0,
    input  logic [B_W-1:0] din1,
    input  logic           in_last,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [P_W-1:0] dout,
    output logic           out_last
);

    // Product is formed at the wider of the natural product width and P_W so
    // that extension past A_W+B_W follows operand signedness for free.
    localparam int unsigned E_W = A_W + B_W;
    localparam int unsigned M_W = (P_W > E_W) ? P_W : E_W;

    logic           adv;
    logic           v0_q;
    logic           last0_q;
    logic [A_W-1:0] a_q;
    logic [B_W-1:0] b_q;
    logic [M_W-1:0] a_ext;
    logic [M_W-1:0] b_ext;
    logic [P_W-1:0] prod;

    // Signals arriving at the output stage (from the last delay stage, or
    // straight from the multiplier when there are no delay stages).
    logic [P_W-1:0] feed;
    logic           feed_v;
    logic           feed_last;

    logic           out_v_q;
    logic           out_last_q;
    logic [P_W-1:0] dout_q;
    logic [P_W-1:0] acc_q;
    logic [P_W-1:0] sum;

    // The whole pipeline moves together; a full output register blocks it.
    always_comb begin
        adv = ce & (~out_v_q | out_ready);
    end

    assign in_ready  = adv;
    assign out_valid = out_v_q;
    assign out_last  = out_last_q;
    assign dout      = dout_q;

    // Operand extension and truncating multiply.
    always_comb begin
        a_ext = {{(M_W - A_W){A_SIGNED & a_q[A_W-1]}}, a_q};
        b_ext = {{(M_W - B_W){B_SIGNED & b_q[B_W-1]}}, b_q};
        prod  = P_W'(a_ext * b_ext);
        sum   = acc_q + feed;
    end

    // Stage 0: operand capture; a bubble is loaded when no beat is offered.
    always_ff @(posedge clk) begin
        if (reset) begin
            v0_q    <= 1'b0;
            last0_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
        end else if (adv) begin
            v0_q    <= in_valid;
            last0_q <= in_valid & (in_last | ~ACC_EN);
            a_q     <= din0;
            b_q     <= din1;
        end
    end

    if (STAGES == 2) begin : g_no_dly
        assign feed      = prod;
        assign feed_v    = v0_q;
        assign feed_last = last0_q;
    end else begin : g_dly
        localparam int unsigned D = STAGES - 2;

        logic [P_W-1:0] dly_p [D];
        logic [D-1:0]   dly_v;
        logic [D-1:0]   dly_last;

        // Stages 1..STAGES-2: product register followed by plain delay.
        always_ff @(posedge clk) begin
            if (reset) begin
                dly_v    <= '0;
                dly_last <= '0;
                for (int i = 0; i < int'(D); i++) begin
                    dly_p[i] <= '0;
                end
            end else if (adv) begin
                dly_p[0]    <= prod;
                dly_v[0]    <= v0_q;
                dly_last[0] <= last0_q;
                for (int i = 1; i < int'(D); i++) begin
                    dly_p[i]    <= dly_p[i-1];
                    dly_v[i]    <= dly_v[i-1];
                    dly_last[i] <= dly_last[i-1];
                end
            end
        end

        assign feed      = dly_p[D-1];
        assign feed_v    = dly_v[D-1];
        assign feed_last = dly_last[D-1];
    end

    // Output stage: plain result register, or accumulator that only emits on
    // the closing beat of a group and restarts from zero afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_v_q    <= 1'b0;
            out_last_q <= 1'b0;
            dout_q     <= '0;
            acc_q      <= '0;
        end else if (adv) begin
            if (feed_v && (!ACC_EN || feed_last)) begin
                out_v_q    <= 1'b1;
                out_last_q <= 1'b1;
                dout_q     <= ACC_EN ? sum : feed;
                acc_q      <= '0;
            end else if (feed_v) begin
                out_v_q    <= 1'b0;
                out_last_q <= 1'b0;
                acc_q      <= sum;
            end else begin
                out_v_q    <= 1'b0;
                out_last_q <= 1'b0;
            end
        end
    end

endmodule
